// File: rtl/elastic_dff_pipeline_pkg.sv
// Shared defaults and helpers for the elastic register pipeline.
// Occupancy width is derived from the stage count.
package elastic_dff_pipeline_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 3;
  localparam int DEF_RST_VAL = 0;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_dff_stage.sv
// One elastic register slot: data plus valid bit.
// Accepts whenever it is empty or its contents move on.
module elastic_dff_stage #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclr,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             rdy_down,
  output logic             rdy_up,
  output logic             vld,
  output logic [WIDTH-1:0] data
);

  assign rdy_up = ~vld | rdy_down;

  // slot register: clear wins, data only moves with a valid word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= 1'b0;
      data <= RST_VAL;
    end else if (sclr) begin
      vld  <= 1'b0;
      data <= RST_VAL;
    end else if (rdy_up) begin
      vld <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/elastic_dff_pipeline.sv
// DEPTH-stage elastic register chain with valid/ready
// handshake, bubble collapse and occupancy counter.
module elastic_dff_pipeline
  import elastic_dff_pipeline_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter int               DEPTH   = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEF_RST_VAL),
  localparam int              OW      = occ_w(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SCLR,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [OW-1:0]    OCCUPANCY
);

  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] data [DEPTH];
  logic             in_xfer;
  logic             out_xfer;

  assign rdy[DEPTH] = OUT_READY;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;

    if (i == 0) begin : g_head
      assign up_valid = IN_VALID;
      assign up_data  = IN_DATA;
    end else begin : g_body
      assign up_valid = vld[i-1];
      assign up_data  = data[i-1];
    end

    elastic_dff_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk      (CLK),
      .rst      (RST),
      .sclr     (SCLR),
      .up_valid (up_valid),
      .up_data  (up_data),
      .rdy_down (rdy[i+1]),
      .rdy_up   (rdy[i]),
      .vld      (vld[i]),
      .data     (data[i])
    );
  end

  // a clearing cycle hides both ends so no handshake completes
  assign IN_READY  = rdy[0] & ~SCLR;
  assign OUT_VALID = vld[DEPTH-1] & ~SCLR;
  assign OUT_DATA  = data[DEPTH-1];

  assign in_xfer  = IN_VALID & IN_READY;
  assign out_xfer = OUT_VALID & OUT_READY;

  // occupancy tracks accepts minus emits
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OCCUPANCY <= '0;
    end else if (SCLR) begin
      OCCUPANCY <= '0;
    end else if (in_xfer && !out_xfer) begin
      OCCUPANCY <= OCCUPANCY + OW'(1);
    end else if (!in_xfer && out_xfer) begin
      OCCUPANCY <= OCCUPANCY - OW'(1);
    end
  end

  // counter must mirror the number of live slots
  always @(posedge CLK) begin
    if (!RST) begin
      assert ($countones(vld) == int'(OCCUPANCY));
    end
  end

endmodule

// File: tb/tb_elastic_dff_pipeline.sv
// Directed bench for elastic_dff_pipeline, WIDTH=8 DEPTH=3.
// One task per scenario, inline comparisons.
module tb_elastic_dff_pipeline;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] occ;

  int checks = 0;
  int errors = 0;

  elastic_dff_pipeline #(
    .WIDTH   (8),
    .DEPTH   (3),
    .RST_VAL (8'h00)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .SCLR      (sclr),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN_DATA   (in_data),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT_DATA  (out_data),
    .OCCUPANCY (occ)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; sclr = 1'b0;
    in_valid = 1'b0; in_data = 8'h00;
    out_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_ovalid got %b want 0", out_valid);
    end
    checks++;
    if (out_data !== 8'h00) begin
      errors++; $display("FAIL rst_odata got %h want 00", out_data);
    end
    checks++;
    if (occ !== 2'd0) begin
      errors++; $display("FAIL rst_occ got %0d want 0", occ);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_iready got %b want 1", in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    logic [7:0] vin [3];
    vin[0] = 8'h11; vin[1] = 8'h22; vin[2] = 8'h33;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = vin[i];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL str_iready[%0d] got %b want 1", i, in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL str_early_ov[%0d] got %b want 0", i, out_valid);
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (occ !== 2'd3) begin
      errors++; $display("FAIL str_occ got %0d want 3", occ);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== vin[i]) begin
        errors++;
        $display("FAIL str_out[%0d] got %b/%h want 1/%h",
                 i, out_valid, out_data, vin[i]);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || occ !== 2'd0) begin
      errors++;
      $display("FAIL str_drain got %b/%0d want 0/0", out_valid, occ);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hA1; tick();
    in_data = 8'hA2; tick();
    in_data = 8'hA3; tick();
    in_data = 8'hA4;
    #1;
    checks++;
    if (occ !== 2'd3) begin
      errors++; $display("FAIL bp_occ got %0d want 3", occ);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_iready got %b want 0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA1 || occ !== 2'd3) begin
      errors++;
      $display("FAIL bp_hold got %b/%h/%0d want 1/a1/3",
               out_valid, out_data, occ);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_comb_ready got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_data !== 8'hA2 || occ !== 2'd3) begin
      errors++;
      $display("FAIL bp_swap got %h/%0d want a2/3", out_data, occ);
    end
    tick(); tick();
    checks++;
    if (out_data !== 8'hA4 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_last got %b/%h want 1/a4", out_valid, out_data);
    end
    tick();
    checks++;
    if (occ !== 2'd0) begin
      errors++; $display("FAIL bp_empty got %0d want 0", occ);
    end
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hB1; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_data = 8'hB2; tick();
    in_valid = 1'b0; tick();
    #1;
    checks++;
    if (occ !== 2'd2) begin
      errors++; $display("FAIL bub_occ got %0d want 2", occ);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bub_iready got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hB1) begin
      errors++;
      $display("FAIL bub_out got %b/%h want 1/b1", out_valid, out_data);
    end
  endtask

  task automatic test_sclr();
    sclr = 1'b1; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sclr_gate got %b/%b want 0/0", in_ready, out_valid);
    end
    tick();
    sclr = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (occ !== 2'd0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL sclr_after got %0d/%b/%h want 0/0/00",
               occ, out_valid, out_data);
    end
    tick(); tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || occ !== 2'd0) begin
      errors++;
      $display("FAIL sclr_noleak got %b/%0d want 0/0", out_valid, occ);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hD1; tick();
    in_data = 8'hD2; tick();
    in_data = 8'hD3; tick();
    in_valid = 1'b0;
    checks++;
    if (occ !== 2'd3) begin
      errors++; $display("FAIL ar_fill got %0d want 3", occ);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || occ !== 2'd0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL ar_async got %b/%0d/%h want 0/0/00",
               out_valid, occ, out_data);
    end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hC1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL ar_lat[%0d] got %b want 0", i, out_valid);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hC1) begin
      errors++;
      $display("FAIL ar_c1 got %b/%h want 1/c1", out_valid, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || occ !== 2'd0) begin
      errors++;
      $display("FAIL ar_end got %b/%0d want 0/0", out_valid, occ);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_sclr();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
